// File: rtl/riscv_pkg.sv
// Shared RV32I fetch definitions: opcodes, NOP encoding, fetch-buffer entry and B-type immediate decode.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_LW    = 7'b000_0011;
  localparam logic [6:0] OPC_SW    = 7'b010_0011;
  localparam logic [6:0] OPC_BEQ   = 7'b110_0011;
  localparam logic [6:0] OPC_ALUOP = 7'b011_0011;

  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic            pred;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ir;
  } fetch_entry_t;

  // Sign-extended byte offset of a B-type instruction.
  function automatic logic [XLEN-1:0] b_imm(input logic [XLEN-1:0] ir);
    return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Synchronous fetch buffer of {pred, pc, ir} entries with flush; the head entry is read straight from storage.
module riscv_fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy is tracked entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/riscv_fetch_stage.sv
// RISC-V IF stage: owns the PC, issues imem reads under a credit rule and buffers responses for decode.
// Optional static BTFN prediction is enabled by defining RISCV_FETCH_PREDICT_EN.
module riscv_fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter int          IMEM_AW    = 10
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               ifid_valid,
  input  logic               ifid_ready,
  output logic [31:0]        ifid_ir,
  output logic [31:0]        ifid_pc,
  output logic               ifid_pred_taken
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   pc;
  logic [31:0]   next_pc;
  logic [31:0]   issue_pc;
  logic [31:0]   target;
  logic          inflight;
  logic          drop;
  logic          issue;
  logic          push;
  logic          pop;
  logic          predict;
  logic [CW:0]   credit;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  fetch_entry_t  fifo_head;
  fetch_entry_t  push_data;

  // An in-flight read reserves a slot, so a response always has room when it lands.
  assign pop    = ifid_valid & ifid_ready;
  assign credit = (CW+1)'(fifo_count) - (CW+1)'(pop) + (CW+1)'(inflight);
  assign issue  = !rst && !redirect_valid && (credit < (CW+1)'(FIFO_DEPTH));
  assign push   = inflight && !drop && !redirect_valid && !rst;

`ifdef RISCV_FETCH_PREDICT_EN
  assign predict = push && (imem_rdata[6:0] == OPC_BEQ) && imem_rdata[31];
  assign target  = issue_pc + b_imm(imem_rdata);
`else
  assign predict = 1'b0;
  assign target  = '0;
`endif

  assign push_data = '{pred: predict, pc: issue_pc, ir: imem_rdata};

  always_comb begin
    next_pc = pc;
    if (redirect_valid)  next_pc = redirect_pc;
    else if (predict)    next_pc = target;
    else if (issue)      next_pc = pc + 32'd4;
  end

  // A prediction discards the sequential read issued alongside it; a redirect needs no drop
  // because its own cycle never issues and the arriving response is blocked by the flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      issue_pc <= '0;
      inflight <= 1'b0;
      drop     <= 1'b0;
    end else begin
      pc       <= next_pc;
      inflight <= issue;
      drop     <= predict && issue;
      if (issue) issue_pc <= pc;
    end
  end

  riscv_fetch_fifo #(.DEPTH(FIFO_DEPTH), .CW(CW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always @(posedge clk) begin
    if (!rst && !redirect_valid)
      assert (!(push && fifo_full)) else $error("fetch buffer push while full");
  end

  assign imem_req        = issue;
  assign imem_addr       = pc[IMEM_AW+1:2];
  assign ifid_valid      = !fifo_empty;
  assign ifid_ir         = ifid_valid ? fifo_head.ir : NOP;
  assign ifid_pc         = ifid_valid ? fifo_head.pc : 32'h0;
  assign ifid_pred_taken = ifid_valid ? fifo_head.pred : 1'b0;

endmodule

// File: tb/tb_riscv_fetch_stage.sv
// Directed self-checking bench for riscv_fetch_stage; imem word at address a holds a*4 unless patched.
module tb_riscv_fetch_stage;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ifid_valid;
  logic        ifid_ready;
  logic [31:0] ifid_ir;
  logic [31:0] ifid_pc;
  logic        ifid_pred_taken;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_pc;
  logic [31:0] imem [1024];

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;
  localparam logic [31:0] BEQ_M16  = 32'hFE00_08E3;

  riscv_fetch_stage #(.RESET_PC(32'h0), .FIFO_DEPTH(2), .IMEM_AW(10)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .ifid_valid      (ifid_valid),
    .ifid_ready      (ifid_ready),
    .ifid_ir         (ifid_ir),
    .ifid_pc         (ifid_pc),
    .ifid_pred_taken (ifid_pred_taken)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    for (int i = 0; i < 1024; i++) imem[i] = i * 4;
  end

  always @(posedge clk) begin
    if (imem_req) imem_rdata <= imem[imem_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  // Drive one cycle's inputs just after the falling edge, then let combinational outputs settle.
  task automatic applyStimulus(input logic rst_v, input logic redir_v, input logic [31:0] redir_pc_v,
                               input logic ready_v);
    @(negedge clk);
    rst            = rst_v;
    redirect_valid = redir_v;
    redirect_pc    = redir_pc_v;
    ifid_ready     = ready_v;
    #1;
  endtask

  task automatic streamCycles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("stream_valid", {31'b0, ifid_valid}, 32'd1);
      checkOutput("stream_pc", ifid_pc, exp_pc);
      checkOutput("stream_ir", ifid_ir, exp_pc);
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic waitValid(input int max_cycles);
    int n;
    n = 0;
    do begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      n++;
    end while (!ifid_valid && n < max_cycles);
    if (!ifid_valid) checkOutput("wait_valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout actual=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; ifid_ready = 1'b1;

    // Test 1: reset state and start-up stream.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("rst_valid", {31'b0, ifid_valid}, 32'd0);
    checkOutput("rst_ir", ifid_ir, NOP_WORD);
    checkOutput("rst_pc", ifid_pc, 32'h0);
    checkOutput("rst_pred", {31'b0, ifid_pred_taken}, 32'd0);
    checkOutput("rst_req", {31'b0, imem_req}, 32'd0);

    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("c0_req", {31'b0, imem_req}, 32'd1);
    checkOutput("c0_addr", {22'b0, imem_addr}, 32'd0);
    checkOutput("c0_valid", {31'b0, ifid_valid}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("c1_addr", {22'b0, imem_addr}, 32'd1);
    checkOutput("c1_valid", {31'b0, ifid_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
      checkOutput("start_valid", {31'b0, ifid_valid}, 32'd1);
      checkOutput("start_pc", ifid_pc, 32'(i * 4));
      checkOutput("start_ir", ifid_ir, 32'(i * 4));
      checkOutput("start_addr", {22'b0, imem_addr}, 32'(i + 2));
    end

    // Test 2: decode stalls for 5 cycles; head holds and issue stops.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
      checkOutput("stall_pc", ifid_pc, 32'd12);
      checkOutput("stall_ir", ifid_ir, 32'd12);
      checkOutput("stall_req", {31'b0, imem_req}, 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("resume_pc", ifid_pc, 32'd12);
    checkOutput("resume_req", {31'b0, imem_req}, 32'd1);
    checkOutput("resume_addr", {22'b0, imem_addr}, 32'd5);
    exp_pc = 32'd16;
    streamCycles(4);

    // Test 3: redirect with a read in flight.
    applyStimulus(1'b0, 1'b1, 32'h100, 1'b1);
    checkOutput("redir_req", {31'b0, imem_req}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("redir_p1_valid", {31'b0, ifid_valid}, 32'd0);
    checkOutput("redir_p1_req", {31'b0, imem_req}, 32'd1);
    checkOutput("redir_p1_addr", {22'b0, imem_addr}, 32'h40);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("redir_p2_valid", {31'b0, ifid_valid}, 32'd0);
    checkOutput("redir_p2_addr", {22'b0, imem_addr}, 32'h41);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("redir_p3_valid", {31'b0, ifid_valid}, 32'd1);
    checkOutput("redir_p3_pc", ifid_pc, 32'h100);
    checkOutput("redir_p3_ir", ifid_ir, 32'h100);
    exp_pc = 32'h104;
    streamCycles(3);

    // Test 4: redirect during pop and push, then a second redirect that must win.
    applyStimulus(1'b0, 1'b1, 32'h300, 1'b1);
    checkOutput("b2b_head_pc", ifid_pc, 32'h110);
    checkOutput("b2b_req0", {31'b0, imem_req}, 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h100, 1'b1);
    checkOutput("b2b_valid1", {31'b0, ifid_valid}, 32'd0);
    checkOutput("b2b_req1", {31'b0, imem_req}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("b2b_addr", {22'b0, imem_addr}, 32'h40);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("b2b_valid3", {31'b0, ifid_valid}, 32'd0);
    exp_pc = 32'h100;
    streamCycles(4);

    // Test 5: backward BEQ at 0x20.
    imem[8] = BEQ_M16;
    applyStimulus(1'b0, 1'b1, 32'h18, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    exp_pc = 32'h18;
    streamCycles(2);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("beq_pc", ifid_pc, 32'h20);
    checkOutput("beq_ir", ifid_ir, BEQ_M16);
`ifdef RISCV_FETCH_PREDICT_EN
    checkOutput("beq_pred", {31'b0, ifid_pred_taken}, 32'd1);
    exp_pc = 32'h10;
`else
    checkOutput("beq_pred", {31'b0, ifid_pred_taken}, 32'd0);
    exp_pc = 32'h24;
`endif
    waitValid(8);
    checkOutput("beq_next_pc", ifid_pc, exp_pc);
    checkOutput("beq_next_pred", {31'b0, ifid_pred_taken}, 32'd0);
    imem[8] = 32'h20;
    exp_pc = exp_pc + 32'd4;
    streamCycles(2);

    // Test 6: reset mid-stream with a read in flight.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
    checkOutput("mrst_req", {31'b0, imem_req}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("mrst_valid", {31'b0, ifid_valid}, 32'd0);
    checkOutput("mrst_ir", ifid_ir, NOP_WORD);
    checkOutput("mrst_addr", {22'b0, imem_addr}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("mrst_valid2", {31'b0, ifid_valid}, 32'd0);
    exp_pc = 32'h0;
    streamCycles(2);

    // Test 7: PC wraps past the top of the address space; imem address truncates.
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("wrap_addr_top", {22'b0, imem_addr}, 32'h3FF);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("wrap_addr_zero", {22'b0, imem_addr}, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("wrap_pc_top", ifid_pc, 32'hFFFF_FFFC);
    checkOutput("wrap_ir_top", ifid_ir, 32'hFFC);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    checkOutput("wrap_pc_zero", ifid_pc, 32'h0);
    checkOutput("wrap_ir_zero", ifid_ir, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
